sll_seq: RTL and testbench
==========================

SLL_SEQ -- requirements
Module: sll_seq

Interface
Parameters: none; datapath width fixed at 32.
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, request a shift; sampled only when busy=0.
REQ-004 SHALL have port A, input, 32, operand to shift left.
REQ-005 SHALL have port B, input, 32, shift amount; only B[4:0] used.
REQ-006 SHALL have port Op, input, 4, ALU opcode; ignored, for ALU-slice port compatibility.
REQ-007 SHALL have port busy, output, 1, operation in progress; start ignored while high.
REQ-008 SHALL have port done, output, 1, one-cycle pulse; Result and Carryout valid.
REQ-009 SHALL have port Result, output, 32, A shifted left logically by B[4:0], zero-filled.
REQ-010 SHALL have port Carryout, output, 1, last bit shifted out of bit 31.
REQ-011 SHALL have port Overflow, output, 1, constant 0.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge E0 SHALL capture A into a working register and B[4:0] into a shift-amount register, clear the stage counter, and go to SHIFT.
REQ-014 In SHIFT, at edges E1..E5, stage k (k=0..4) SHALL shift the working register left by 2^k if the captured amount bit k=1, else hold it.
REQ-015 Edges E1..E5 SHALL occur in exactly 5 cycles, independent of the shift amount, including amount 0.
REQ-016 After E5, the FSM SHALL enter DONE, drive done=1 for exactly one cycle, and update Result and Carryout at E5.
REQ-017 DONE SHALL return to IDLE at the next edge, E6.
REQ-018 Carryout SHALL equal captured A[32-n] for amount n in 1..31, and 0 for n=0.
REQ-019 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-020 start=1 in DONE SHALL be accepted as in IDLE, giving back-to-back operations with no idle gap.
REQ-021 start while busy=1 SHALL be ignored; captured operands SHALL not change.
REQ-022 Changes on A or B after capture SHALL not affect the in-flight result.
REQ-023 Result and Carryout SHALL hold their last completed values until the next completion.
REQ-024 Op, B[31:5] and Overflow SHALL never affect any state.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, Result=0x00000000, Carryout=0, Overflow=0, and clear all internal registers.
REQ-026 Reset during SHIFT SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-027 start SHALL be ignored while rst_n=0; the first capture SHALL be at the first edge with rst_n=1 and start=1.

Verification
REQ-028 A=0x00000001, B=31, start pulse -> busy high 5 cycles; done pulse; Result=0x80000000; Carryout=0.
REQ-029 A=0x80000001, B=1 -> Result=0x00000002, Carryout=1; A=0xF0000000, B=4 -> Result=0x00000000, Carryout=1.
REQ-030 A=0x12345678, B=0 -> done still 5 cycles after capture; Result=0x12345678, Carryout=0.
REQ-031 A=0x0000000F, B=0xFFFFFFE4 (amount 4), Op=0xF -> Result=0x000000F0; Overflow=0 throughout.
REQ-032 Start A=1, B=3; hold start high with A=0xFFFFFFFF during busy -> Result=0x00000008; start=1 in DONE with A=2, B=1 -> captured, next Result=0x00000004.
REQ-033 Assert rst_n=0 on cycle 3 of SHIFT, release after 2 cycles -> outputs 0 immediately; no done pulse; a new start completes normally.

Source files
------------

// File: rtl/sll_seq.sv
// rtl/sll_seq.sv - sequential 32-bit logical left shifter, five-stage barrel walked one stage per cycle
module sll_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  Op,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        Carryout,
  output logic        Overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] work_q;
  logic [31:0] work_d;
  logic [4:0]  amt_q;
  logic [2:0]  stage_q;
  logic        carry_q;
  logic        carry_d;
  logic [31:0] result_q;
  logic        carryout_q;
  logic        busy_q;
  logic        done_q;

  // Op and the upper amount bits exist only for ALU-slice port compatibility.
  logic unused_inputs;
  assign unused_inputs = ^{Op, B[31:5]};

  // One barrel stage per cycle: stage k shifts by 2^k when amount bit k is set.
  // The bit landing in carry is the last one pushed past bit 31 by that stage;
  // because earlier stages already moved the word, the final stage that fires
  // leaves carry equal to the captured A[32-n].
  always_comb begin
    work_d  = work_q;
    carry_d = carry_q;
    case (stage_q)
      3'd0: if (amt_q[0]) begin
        carry_d = work_q[31];
        work_d  = {work_q[30:0], 1'b0};
      end
      3'd1: if (amt_q[1]) begin
        carry_d = work_q[30];
        work_d  = {work_q[29:0], 2'b0};
      end
      3'd2: if (amt_q[2]) begin
        carry_d = work_q[28];
        work_d  = {work_q[27:0], 4'b0};
      end
      3'd3: if (amt_q[3]) begin
        carry_d = work_q[24];
        work_d  = {work_q[23:0], 8'b0};
      end
      3'd4: if (amt_q[4]) begin
        carry_d = work_q[16];
        work_d  = {work_q[15:0], 16'b0};
      end
      default: begin
        work_d  = work_q;
        carry_d = carry_q;
      end
    endcase
  end

  // Control FSM with registered busy/done and result holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= 32'h0;
      amt_q      <= 5'h0;
      stage_q    <= 3'h0;
      carry_q    <= 1'b0;
      result_q   <= 32'h0;
      carryout_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts start exactly like IDLE so operations can run back to back.
          if (start) begin
            work_q  <= A;
            amt_q   <= B[4:0];
            stage_q <= 3'h0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          stage_q <= stage_q + 3'h1;
          if (stage_q == 3'd4) begin
            result_q   <= work_d;
            carryout_q <= carry_d;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result   = result_q;
  assign Carryout = carryout_q;
  assign Overflow = 1'b0;

endmodule

// File: tb/tb_sll_seq.sv
// tb/tb_sll_seq.sv - scoreboard bench for sll_seq with directed shift vectors
module tb_sll_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        Carryout;
  logic        Overflow;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic        done_prev = 1'b0;

  logic [31:0] va [7];
  logic [31:0] vb [7];
  logic [3:0]  vop[7];
  logic [31:0] vr [7];
  logic        vc [7];

  sll_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Op      (Op),
    .busy    (busy),
    .done    (done),
    .Result  (Result),
    .Carryout(Carryout),
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("overflow_zero", {31'h0, Overflow}, 32'h0);
      if (done) begin
        chk("done_single_pulse", {31'h0, done_prev}, 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("result", Result, e[31:0]);
          chk("carryout", {31'h0, Carryout}, {31'h0, e[32]});
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // Called at the negedge just after capture; returns at the negedge showing done.
  task automatic wait_done();
    int cyc = 1;
    int bc  = 0;
    while (!done && cyc < 30) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc - 1, 32'd5);
    chk("busy_cycles", bc, 32'd5);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] er, input logic ec);
    A = a; B = b; Op = op; start = 1'b1;
    exp_q.push_back({ec, er});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = 32'hA5A5A5A5;
    B = 32'h5A5A5A5A;
    Op = 4'h3;
    wait_done();
  endtask

  initial begin
    va[0] = 32'h00000001; vb[0] = 32'd31;        vop[0] = 4'h0; vr[0] = 32'h80000000; vc[0] = 1'b0;
    va[1] = 32'h80000001; vb[1] = 32'd1;         vop[1] = 4'h0; vr[1] = 32'h00000002; vc[1] = 1'b1;
    va[2] = 32'hF0000000; vb[2] = 32'd4;         vop[2] = 4'h0; vr[2] = 32'h00000000; vc[2] = 1'b1;
    va[3] = 32'h12345678; vb[3] = 32'd0;         vop[3] = 4'h0; vr[3] = 32'h12345678; vc[3] = 1'b0;
    va[4] = 32'h0000000F; vb[4] = 32'hFFFFFFE4;  vop[4] = 4'hF; vr[4] = 32'h000000F0; vc[4] = 1'b0;
    va[5] = 32'hDEADBEEF; vb[5] = 32'd9;         vop[5] = 4'h7; vr[5] = 32'h5B7DDE00; vc[5] = 1'b1;
    va[6] = 32'hFFFFFFFF; vb[6] = 32'd31;        vop[6] = 4'h0; vr[6] = 32'h80000000; vc[6] = 1'b1;

    rst_n = 1'b0; start = 1'b1; A = 32'hFFFFFFFF; B = 32'd5; Op = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_result", Result, 32'h0);
    chk("reset_carry", {31'h0, Carryout}, 32'h0);
    chk("reset_overflow", {31'h0, Overflow}, 32'h0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vop[i], vr[i], vc[i]);
    end

    // start held through busy with a changing A, then a back-to-back start from DONE
    A = 32'h00000001; B = 32'd3; Op = 4'h0; start = 1'b1;
    exp_q.push_back({1'b0, 32'h00000008});
    @(posedge clk);
    @(negedge clk);
    A = 32'hFFFFFFFF;
    wait_done();
    A = 32'h00000002; B = 32'd1; start = 1'b1;
    exp_q.push_back({1'b0, 32'h00000004});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    repeat (4) @(negedge clk);
    chk("result_hold", Result, 32'h00000004);
    chk("carry_hold", {31'h0, Carryout}, 32'h0);
    chk("idle_not_busy", {31'h0, busy}, 32'h0);

    // Abort on cycle 3 of SHIFT
    A = 32'h00000005; B = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_result", Result, 32'h0);
    chk("abort_carry", {31'h0, Carryout}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_abort_busy", {31'h0, busy}, 32'h0);
    chk("post_abort_result", Result, 32'h0);

    run_op(32'hC0000003, 32'd2, 4'h0, 32'h0000000C, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
